// File: rtl/dt_engine_param.sv
// Two-pass distance transform (chessboard or city-block) from the sti ROM into the res RAM, in place.
// Define DT_CYCLE_CNT_EN to add the saturating 32-bit busy-cycle counter port cycle_cnt.
module dt_engine_param #(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int STI_W  = 16,
   parameter int PIX_W  = 8,
   parameter int STI_AW = 10,
   parameter int RES_AW = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              metric,
   output logic              busy,
   output logic              done,
   output logic              sti_rd,
   output logic [STI_AW-1:0] sti_addr,
   input  logic [STI_W-1:0]  sti_di,
   output logic              res_wr,
   output logic              res_rd,
   output logic [RES_AW-1:0] res_addr,
   output logic [PIX_W-1:0]  res_do,
   input  logic [PIX_W-1:0]  res_di
`ifdef DT_CYCLE_CNT_EN
   ,
   output logic [31:0]       cycle_cnt
`endif
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = RES_AW - CW;
   localparam int SW = $clog2(STI_W);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COPY_RD = 3'd1;
   localparam logic [2:0] S_COPY_WR = 3'd2;
   localparam logic [2:0] S_FWD_RD  = 3'd3;
   localparam logic [2:0] S_FWD_WB  = 3'd4;
   localparam logic [2:0] S_BWD_RD  = 3'd5;
   localparam logic [2:0] S_BWD_WB  = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   localparam logic [1:0] PH_REQ  = 2'd0;
   localparam logic [1:0] PH_WAIT = 2'd1;
   localparam logic [1:0] PH_DATA = 2'd2;

   localparam logic [RES_AW-1:0] P_ZERO   = {RES_AW{1'b0}};
   localparam logic [RES_AW-1:0] P_ONE    = {{(RES_AW-1){1'b0}}, 1'b1};
   localparam logic [RES_AW-1:0] P_LAST   = {RES_AW{1'b1}};
   localparam logic [RES_AW-1:0] W_A      = RES_AW'(IMG_W);
   localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 1);
   localparam logic [PIX_W-1:0]  PIX_ZERO = {PIX_W{1'b0}};
   localparam logic [PIX_W-1:0]  PIX_MAX  = {PIX_W{1'b1}};

   function automatic logic [PIX_W-1:0] sat_inc(input logic [PIX_W-1:0] v);
      logic [PIX_W:0] s;
      s = {1'b0, v} + {{PIX_W{1'b0}}, 1'b1};
      if (s[PIX_W]) begin
         sat_inc = PIX_MAX;
      end else begin
         sat_inc = s[PIX_W-1:0];
      end
   endfunction

   function automatic logic [PIX_W-1:0] umin(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
      umin = (a < b) ? a : b;
   endfunction

   logic [2:0]        state_q, state_d;
   logic [1:0]        ph_q, ph_d;
   logic [RES_AW-1:0] p_q, p_d;
   logic [2:0]        idx_q, idx_d;
   logic              metric_q, metric_d;
   logic [STI_W-1:0]  word_q, word_d;
   logic [PIX_W-1:0]  cen_q, cen_d;
   logic [PIX_W-1:0]  min_q, min_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              sti_rd_q, sti_rd_d;
   logic [STI_AW-1:0] sti_addr_q, sti_addr_d;
   logic              res_wr_q, res_wr_d;
   logic              res_rd_q, res_rd_d;
   logic [RES_AW-1:0] res_addr_q, res_addr_d;
   logic [PIX_W-1:0]  res_do_q, res_do_d;

   logic [CW-1:0]     col_s;
   logic [RW-1:0]     row_s;
   logic              top_s, bot_s, left_s, right_s;
   logic              fwd_s;
   logic              nb_use_s, nb_out_s;
   logic [RES_AW-1:0] nb_addr_s;
   logic [RES_AW-1:0] adv_p_s;
   logic [2:0]        adv_state_s;
   logic [2:0]        wb_state_s;
   logic [SW-1:0]     bit_s;

   assign col_s   = p_q[CW-1:0];
   assign row_s   = p_q[RES_AW-1:CW];
   assign top_s   = (row_s == {RW{1'b0}});
   assign bot_s   = (row_s == ROW_LAST);
   assign left_s  = (col_s == {CW{1'b0}});
   assign right_s = (col_s == COL_LAST);
   assign fwd_s   = (state_q == S_FWD_RD) || (state_q == S_FWD_WB);
   assign wb_state_s = fwd_s ? S_FWD_WB : S_BWD_WB;
   // Bit STI_W-1 of a ROM word holds the lowest-address pixel.
   assign bit_s   = ~p_q[SW-1:0];

   // Neighbour slot table: slot use under the latched metric, out-of-image flag and RAM address.
   always_comb begin
      nb_use_s  = 1'b0;
      nb_out_s  = 1'b0;
      nb_addr_s = p_q;
      if (fwd_s) begin
         case (idx_q)
            3'd1: begin nb_use_s = ~metric_q; nb_out_s = top_s | left_s;  nb_addr_s = p_q - W_A - P_ONE; end
            3'd2: begin nb_use_s = 1'b1;      nb_out_s = top_s;           nb_addr_s = p_q - W_A;         end
            3'd3: begin nb_use_s = ~metric_q; nb_out_s = top_s | right_s; nb_addr_s = p_q - W_A + P_ONE; end
            3'd4: begin nb_use_s = 1'b1;      nb_out_s = left_s;          nb_addr_s = p_q - P_ONE;       end
            default: begin nb_use_s = 1'b0; nb_out_s = 1'b0; nb_addr_s = p_q; end
         endcase
      end else begin
         case (idx_q)
            3'd1: begin nb_use_s = 1'b1;      nb_out_s = right_s;         nb_addr_s = p_q + P_ONE;       end
            3'd2: begin nb_use_s = ~metric_q; nb_out_s = bot_s | left_s;  nb_addr_s = p_q + W_A - P_ONE; end
            3'd3: begin nb_use_s = 1'b1;      nb_out_s = bot_s;           nb_addr_s = p_q + W_A;         end
            3'd4: begin nb_use_s = ~metric_q; nb_out_s = bot_s | right_s; nb_addr_s = p_q + W_A + P_ONE; end
            default: begin nb_use_s = 1'b0; nb_out_s = 1'b0; nb_addr_s = p_q; end
         endcase
      end
   end

   // Next pixel in the current raster direction, or the phase following the last pixel.
   always_comb begin
      adv_p_s     = p_q;
      adv_state_s = state_q;
      if (fwd_s) begin
         if (p_q == P_LAST) begin
            adv_state_s = S_BWD_RD;
         end else begin
            adv_p_s     = p_q + P_ONE;
            adv_state_s = S_FWD_RD;
         end
      end else begin
         if (p_q == P_ZERO) begin
            adv_state_s = S_DONE;
         end else begin
            adv_p_s     = p_q - P_ONE;
            adv_state_s = S_BWD_RD;
         end
      end
   end

   // Main sequencer: each memory read spends request, strobe and data cycles; strobes default low.
   always_comb begin
      state_d    = state_q;
      ph_d       = ph_q;
      p_d        = p_q;
      idx_d      = idx_q;
      metric_d   = metric_q;
      word_d     = word_q;
      cen_d      = cen_q;
      min_d      = min_q;
      sti_rd_d   = 1'b0;
      sti_addr_d = sti_addr_q;
      res_wr_d   = 1'b0;
      res_rd_d   = 1'b0;
      res_addr_d = res_addr_q;
      res_do_d   = res_do_q;
      case (state_q)
         S_IDLE: begin
            ph_d  = PH_REQ;
            idx_d = 3'd0;
            if (start) begin
               metric_d = metric;
               p_d      = P_ZERO;
               state_d  = S_COPY_RD;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_COPY_RD: begin
            case (ph_q)
               PH_REQ: begin
                  sti_rd_d   = 1'b1;
                  sti_addr_d = p_q[RES_AW-1:SW];
                  ph_d       = PH_WAIT;
               end
               PH_WAIT: ph_d = PH_DATA;
               PH_DATA: begin
                  word_d  = sti_di;
                  ph_d    = PH_REQ;
                  state_d = S_COPY_WR;
               end
               default: ph_d = PH_REQ;
            endcase
         end
         S_COPY_WR: begin
            res_wr_d   = 1'b1;
            res_addr_d = p_q;
            res_do_d   = {{(PIX_W-1){1'b0}}, word_q[bit_s]};
            if (p_q == P_LAST) begin
               p_d     = P_ZERO;
               idx_d   = 3'd0;
               ph_d    = PH_REQ;
               state_d = S_FWD_RD;
            end else begin
               p_d = p_q + P_ONE;
               if (&p_q[SW-1:0]) begin
                  state_d = S_COPY_RD;
               end else begin
                  state_d = S_COPY_WR;
               end
            end
         end
         S_FWD_RD, S_BWD_RD: begin
            case (ph_q)
               PH_REQ: begin
                  if (idx_q == 3'd0) begin
                     res_rd_d   = 1'b1;
                     res_addr_d = p_q;
                     min_d      = PIX_MAX;
                     ph_d       = PH_WAIT;
                  end else if (nb_use_s && !nb_out_s) begin
                     res_rd_d   = 1'b1;
                     res_addr_d = nb_addr_s;
                     ph_d       = PH_WAIT;
                  end else begin
                     // Unused slots cost nothing; out-of-image neighbours count as background.
                     if (nb_use_s) begin
                        min_d = PIX_ZERO;
                     end else begin
                        min_d = min_q;
                     end
                     if (idx_q == 3'd4) begin
                        idx_d   = 3'd0;
                        state_d = wb_state_s;
                     end else begin
                        idx_d = idx_q + 3'd1;
                     end
                  end
               end
               PH_WAIT: ph_d = PH_DATA;
               PH_DATA: begin
                  ph_d = PH_REQ;
                  if (idx_q == 3'd0) begin
                     if (res_di == PIX_ZERO) begin
                        p_d     = adv_p_s;
                        state_d = adv_state_s;
                     end else begin
                        cen_d = res_di;
                        idx_d = 3'd1;
                     end
                  end else begin
                     min_d = umin(min_q, res_di);
                     if (idx_q == 3'd4) begin
                        idx_d   = 3'd0;
                        state_d = wb_state_s;
                     end else begin
                        idx_d = idx_q + 3'd1;
                     end
                  end
               end
               default: ph_d = PH_REQ;
            endcase
         end
         S_FWD_WB, S_BWD_WB: begin
            res_wr_d   = 1'b1;
            res_addr_d = p_q;
            if (fwd_s) begin
               res_do_d = sat_inc(min_q);
            end else begin
               res_do_d = umin(cen_q, sat_inc(min_q));
            end
            p_d     = adv_p_s;
            state_d = adv_state_s;
            idx_d   = 3'd0;
            ph_d    = PH_REQ;
         end
         S_DONE: begin
            state_d = S_IDLE;
            ph_d    = PH_REQ;
         end
         default: begin
            state_d = S_IDLE;
            ph_d    = PH_REQ;
         end
      endcase
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   // State, datapath and output registers; reset aborts any run in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         ph_q       <= PH_REQ;
         p_q        <= P_ZERO;
         idx_q      <= 3'd0;
         metric_q   <= 1'b0;
         word_q     <= {STI_W{1'b0}};
         cen_q      <= PIX_ZERO;
         min_q      <= PIX_ZERO;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sti_rd_q   <= 1'b0;
         sti_addr_q <= {STI_AW{1'b0}};
         res_wr_q   <= 1'b0;
         res_rd_q   <= 1'b0;
         res_addr_q <= P_ZERO;
         res_do_q   <= PIX_ZERO;
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         p_q        <= p_d;
         idx_q      <= idx_d;
         metric_q   <= metric_d;
         word_q     <= word_d;
         cen_q      <= cen_d;
         min_q      <= min_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         sti_rd_q   <= sti_rd_d;
         sti_addr_q <= sti_addr_d;
         res_wr_q   <= res_wr_d;
         res_rd_q   <= res_rd_d;
         res_addr_q <= res_addr_d;
         res_do_q   <= res_do_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sti_rd   = sti_rd_q;
   assign sti_addr = sti_addr_q;
   assign res_wr   = res_wr_q;
   assign res_rd   = res_rd_q;
   assign res_addr = res_addr_q;
   assign res_do   = res_do_q;

`ifdef DT_CYCLE_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   // Busy-cycle counter: cleared on start acceptance, saturating, frozen while not busy.
   always_comb begin
      if ((state_q == S_IDLE) && start) begin
         cnt_d = 32'd0;
      end else if (busy_q && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= 32'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_dt_engine_param.sv
// Directed bench for dt_engine_param on 8x8 images: a PIX_W=8 instance plus a PIX_W=2 saturation twin.
module tb_dt_engine_param;
   localparam int IW = 8;
   localparam int IH = 8;
   localparam int SWD = 8;
   localparam int SA = 3;
   localparam int RA = 6;

   logic clk, reset, start, metric, fill_req;
   logic busy, done, sti_rd, res_wr, res_rd;
   logic [SA-1:0] sti_addr;
   logic [SWD-1:0] sti_di;
   logic [RA-1:0] res_addr;
   logic [7:0] res_do, res_di;
   logic s_busy, s_done, s_sti_rd, s_res_wr, s_res_rd;
   logic [SA-1:0] s_sti_addr;
   logic [SWD-1:0] s_sti_di;
   logic [RA-1:0] s_res_addr;
   logic [1:0] s_res_do, s_res_di;
`ifdef DT_CYCLE_CNT_EN
   logic [31:0] cycle_cnt, s_cycle_cnt;
`endif

   logic [7:0] rom [0:7];
   logic [7:0] ram8 [0:63];
   logic [1:0] ram2 [0:63];

   int errors = 0;
   int checks = 0;
   int r_busy, r_done, r_wr, r_ovl, r_extra, r_sdone;

   dt_engine_param #(.IMG_W(IW), .IMG_H(IH), .STI_W(SWD), .PIX_W(8), .STI_AW(SA), .RES_AW(RA)) u_dut (
      .clk(clk), .reset(reset), .start(start), .metric(metric), .busy(busy), .done(done),
      .sti_rd(sti_rd), .sti_addr(sti_addr), .sti_di(sti_di), .res_wr(res_wr), .res_rd(res_rd),
      .res_addr(res_addr), .res_do(res_do), .res_di(res_di)
`ifdef DT_CYCLE_CNT_EN
      , .cycle_cnt(cycle_cnt)
`endif
   );

   dt_engine_param #(.IMG_W(IW), .IMG_H(IH), .STI_W(SWD), .PIX_W(2), .STI_AW(SA), .RES_AW(RA)) u_sat (
      .clk(clk), .reset(reset), .start(start), .metric(metric), .busy(s_busy), .done(s_done),
      .sti_rd(s_sti_rd), .sti_addr(s_sti_addr), .sti_di(s_sti_di), .res_wr(s_res_wr), .res_rd(s_res_rd),
      .res_addr(s_res_addr), .res_do(s_res_do), .res_di(s_res_di)
`ifdef DT_CYCLE_CNT_EN
      , .cycle_cnt(s_cycle_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM/RAM models: one-cycle read latency, writes commit at the strobe edge.
   always @(posedge clk) begin
      if (fill_req) begin
         for (int i = 0; i < 64; i++) begin
            ram8[i] <= 8'hAA;
            ram2[i] <= 2'b10;
         end
      end else begin
         if (res_wr) ram8[res_addr] <= res_do;
         if (s_res_wr) ram2[s_res_addr] <= s_res_do;
      end
      if (res_rd) res_di <= ram8[res_addr];
      if (s_res_rd) s_res_di <= ram2[s_res_addr];
      if (sti_rd) sti_di <= rom[sti_addr];
      if (s_sti_rd) s_sti_di <= rom[s_sti_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic load_img(input logic [63:0] img);
      for (int i = 0; i < 8; i++) rom[i] = img[(63 - 8*i) -: 8];
      fill_req = 1'b1;
      @(negedge clk);
      fill_req = 1'b0;
   endtask

   function automatic int nz8(input int skip);
      int n;
      n = 0;
      for (int i = 0; i < 64; i++) if (i != skip && ram8[i] != 8'd0) n++;
      return n;
   endfunction

   // One full run from a negedge; poke re-asserts start mid-run, which must be ignored.
   task automatic run_dt(input logic m, input bit poke);
      int guard;
      r_busy = 0; r_done = 0; r_wr = 0; r_ovl = 0; r_extra = 0; r_sdone = 0; guard = 0;
      metric = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      metric = ~m;
      while (r_done == 0 && guard < 20000) begin
         if (busy) r_busy++;
         if (res_wr) r_wr++;
         if (res_rd && res_wr) r_ovl++;
         if (s_done) r_sdone++;
         if (done) r_done++;
         start = (poke && guard == 200) ? 1'b1 : 1'b0;
         @(negedge clk);
         guard++;
      end
      start = 1'b0;
      check("run_in_budget", {31'd0, guard < 20000}, 32'd1);
      check("done_pulses", r_done, 32'd1);
      check("rd_wr_overlap", r_ovl, 32'd0);
`ifdef DT_CYCLE_CNT_EN
      check("cycle_cnt", cycle_cnt, r_busy);
`endif
      @(negedge clk);
      check("busy_after_done", {busy, done}, 32'd0);
      for (int i = 0; i < 30; i++) begin
         if (busy || done) r_extra++;
         @(negedge clk);
      end
      check("no_restart", r_extra, 32'd0);
`ifdef DT_CYCLE_CNT_EN
      check("cycle_cnt_hold", cycle_cnt, r_busy);
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int guard;
      int quiet;
      reset = 1'b0; start = 1'b0; metric = 1'b0; fill_req = 1'b0;
      for (int i = 0; i < 8; i++) rom[i] = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_outs", {busy, done, sti_rd, res_rd, res_wr, s_busy, s_done, res_addr, res_do}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Reset in the forward pass: outputs drop at once, then the block waits idle.
      load_img(64'hFFFF_FFFF_FFFF_FFFF);
      metric = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (!res_rd && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("fwd_read_seen", {31'd0, guard < 2000}, 32'd1);
      reset = 1'b0;
      #1;
      check("rst_mid_outs", {busy, done, sti_rd, res_rd, res_wr}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      quiet = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (busy || done || sti_rd || res_rd || res_wr) quiet++;
      end
      check("idle_after_rst", quiet, 32'd0);

      // All-zero image, with a start poked mid-run.
      load_img(64'h0);
      run_dt(1'b0, 1'b1);
      check("zero_nonzero_cnt", nz8(-1), 32'd0);
      check("zero_writes", r_wr, 32'd64);

      // Single object pixel at (3,3), both metrics.
      load_img(64'h0000_0010_0000_0000);
      run_dt(1'b0, 1'b0);
      check("dot_c_res27", ram8[27], 32'd1);
      check("dot_c_others", nz8(27), 32'd0);
      check("dot_c_writes", r_wr, 32'd66);
      run_dt(1'b1, 1'b0);
      check("dot_b_res27", ram8[27], 32'd1);
      check("dot_b_others", nz8(27), 32'd0);
      check("dot_b_writes", r_wr, 32'd66);

      // All object except background at (4,4).
      load_img(64'hFFFF_FFFF_F7FF_FFFF);
      run_dt(1'b0, 1'b0);
      check("hole_c_res45", ram8[45], 32'd1);
      check("hole_c_res36", ram8[36], 32'd0);
      check("hole_c_res0", ram8[0], 32'd1);
      check("hole_c_res27", ram8[27], 32'd1);
      check("hole_c_writes", r_wr, 32'd190);
      run_dt(1'b1, 1'b0);
      check("hole_b_res45", ram8[45], 32'd2);
      check("hole_b_res36", ram8[36], 32'd0);
      check("hole_b_res0", ram8[0], 32'd1);
      check("hole_b_res35", ram8[35], 32'd1);

      // All-object image: interior depth and saturation on the 2-bit twin.
      load_img(64'hFFFF_FFFF_FFFF_FFFF);
      run_dt(1'b0, 1'b0);
      check("full_res27", ram8[27], 32'd4);
      check("full_res36", ram8[36], 32'd4);
      check("full_res63", ram8[63], 32'd1);
      check("full_writes", r_wr, 32'd192);
      check("sat_res27", ram2[27], 32'd3);
      check("sat_res9", ram2[9], 32'd2);
      check("sat_done", r_sdone, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
